// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cache_mem_arbiter_pkg: shared encodings and default widths for the    |
// | I/D cache memory-port arbiter.                                        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cache_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 28;
  localparam int unsigned DEF_LINE_W = 128;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_fair.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arb_fair_counter: counts back-to-back D grants taken while I waits    |
// | and forces an I grant once the limit is reached.                      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module arb_fair_counter #(
  parameter int unsigned MAX_D_CONSEC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pend_i,
  input  logic d_pend_i,
  input  logic i_grant_i,
  input  logic d_grant_i,
  output logic force_i_o
);

  localparam int unsigned   CNT_W = 4;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_D_CONSEC);

  logic [CNT_W-1:0] consec_q;
  logic [CNT_W-1:0] consec_d;

  // A D grant with no I waiting breaks the streak; otherwise it saturates.
  always_comb begin
    consec_d = consec_q;
    if (i_grant_i) begin
      consec_d = '0;
    end else if (d_grant_i) begin
      if (!i_pend_i) begin
        consec_d = '0;
      end else if (consec_q != C_MAX) begin
        consec_d = consec_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_q <= '0;
    end else begin
      consec_q <= consec_d;
    end
  end

  assign force_i_o = i_pend_i & d_pend_i & (consec_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cache_mem_arbiter: shares one memory port between I-cache and D-cache |
// | with fixed D priority and a bounded I starvation guard.               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned LINE_W       = DEF_LINE_W,
  parameter int unsigned MAX_D_CONSEC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner,
  output logic              proto_err
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic i_pend;
  logic d_pend;
  logic force_i;
  logic take_i;
  logic take_d;
  logic done_i;
  logic done_d;

  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic              proto_err_q;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  arb_fair_counter #(
    .MAX_D_CONSEC (MAX_D_CONSEC)
  ) u_fair (
    .clk       (clk),
    .rst       (rst),
    .i_pend_i  (i_pend),
    .d_pend_i  (d_pend),
    .i_grant_i (take_i),
    .d_grant_i (take_d),
    .force_i_o (force_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_d) begin
          state_d = GRANT_D;
        end else if (take_i) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant decisions exist only in IDLE; mem_ready counts only inside a grant.
  always_comb begin
    owner  = OWNER_NONE;
    take_i = 1'b0;
    take_d = 1'b0;
    done_i = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        take_i = i_pend & (~d_pend | force_i);
        take_d = d_pend & ~force_i;
      end
      GRANT_I: begin
        owner  = OWNER_I;
        done_i = mem_ready;
      end
      GRANT_D: begin
        owner  = OWNER_D;
        done_d = mem_ready;
      end
      default: owner = OWNER_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (take_i) begin
        mem_read_q  <= 1'b1;
        mem_write_q <= 1'b0;
        mem_addr_q  <= i_addr;
      end else if (take_d) begin
        // A simultaneous read+write request is served as the write-back.
        mem_read_q  <= ~d_write;
        mem_write_q <= d_write;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
      end else if (done_i | done_d) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end

      i_ready_q <= done_i;
      d_ready_q <= done_d;

      if (done_i) begin
        i_rdata_q <= mem_rdata;
      end
      if (done_d && mem_read_q) begin
        d_rdata_q <= mem_rdata;
      end

      if (d_read && d_write) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire
